// File: rtl/peripheral_wb_mpram_arbiter.sv
// peripheral_wb_mpram_arbiter: round-robin Wishbone arbiter giving NM masters turns on one memory port
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; m_* packed per-master request slices
// (master k in slice k) with per-master ack/err and broadcast read data; s_* request to and response
// from the memory port; grant_o one-hot owner, zero when idle.
module peripheral_wb_mpram_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM*3-1:0]      m_cti_i,
    input  logic [NM*2-1:0]      m_bte_i,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [DW-1:0]        m_dat_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic                 s_we_o,
    output logic [2:0]           s_cti_o,
    output logic [1:0]           s_bte_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    input  logic [DW-1:0]        s_dat_i,
    output logic [NM-1:0]        grant_o
);
    localparam int OW = $clog2(NM);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        r_state, w_state_nx;
    logic [OW-1:0] r_owner, w_owner_nx;
    logic [OW-1:0] r_last, w_last_nx;
    logic [WW-1:0] r_wd, w_wd_nx;
    logic [OW-1:0] w_pick, w_idx;
    logic          w_any, w_busy, w_cyc, w_stb, w_we, w_live, w_to;

    // Scan from farthest to nearest after the last owner so the nearest requester is written last.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_idx  = '0;
        for (int i = NM; i >= 1; i--) begin
            w_idx = OW'((int'(r_last) + i) % NM);
            if (m_cyc_i[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_cyc   = 1'b0;
        w_stb   = 1'b0;
        w_we    = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        for (int k = 0; k < NM; k++) begin
            if (OW'(k) == r_owner) begin
                w_cyc   = m_cyc_i[k];
                w_stb   = m_stb_i[k];
                w_we    = m_we_i[k];
                s_adr_o = m_adr_i[k*AW +: AW];
                s_dat_o = m_dat_i[k*DW +: DW];
                s_sel_o = m_sel_i[k*(DW/8) +: DW/8];
                s_cti_o = m_cti_i[k*3 +: 3];
                s_bte_o = m_bte_i[k*2 +: 2];
            end
        end
    end

    assign w_busy  = (r_state == BUSY);
    assign w_live  = w_busy & w_cyc;
    // Timeout fires on the wait cycle that brings the count to TIMEOUT.
    assign w_to    = w_live & w_stb & ~s_ack_i & ~s_err_i & (r_wd == WW'(TIMEOUT - 1));
    assign s_cyc_o = w_live & ~w_to;
    assign s_stb_o = s_cyc_o & w_stb;
    assign s_we_o  = s_cyc_o & w_we;
    assign grant_o = w_busy ? (NM'(1) << r_owner) : '0;
    // Gating with the owner's cyc drops an ack that arrives as the owner abandons the cycle.
    assign m_ack_o = (w_live & s_ack_i) ? grant_o : '0;
    assign m_err_o = (w_live & (s_err_i | w_to)) ? grant_o : '0;
    assign m_dat_o = s_dat_i;
    assign w_wd_nx = (s_stb_o & ~s_ack_i & ~s_err_i) ? r_wd + 1'b1 : '0;

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_last_nx  = r_last;
        if (!w_busy) begin
            if (w_any) begin
                w_state_nx = BUSY;
                w_owner_nx = w_pick;
            end
        end else if (!w_cyc || w_to) begin
            w_state_nx = IDLE;
            w_last_nx  = r_owner;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= OW'(NM - 1);
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_last  <= w_last_nx;
            r_wd    <= w_wd_nx;
        end
    end
endmodule

// File: tb/tb_peripheral_wb_mpram_arbiter.sv
// tb_peripheral_wb_mpram_arbiter: directed scoreboard bench for the round-robin Wishbone arbiter
module tb_peripheral_wb_mpram_arbiter;
    localparam int NM = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*DW/8-1:0] m_sel;
    logic [NM-1:0]     m_we, m_cyc, m_stb, m_ack, m_err, grant;
    logic [NM*3-1:0]   m_cti;
    logic [NM*2-1:0]   m_bte;
    logic [DW-1:0]     m_dat_o, s_dat_o, s_dat_i;
    logic [AW-1:0]     s_adr;
    logic [DW/8-1:0]   s_sel;
    logic              s_we, s_cyc, s_stb, s_ack, s_err;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  gnt;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [2:0]  cti;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    peripheral_wb_mpram_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_dat_o),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cti_o(s_cti), .s_bte_o(s_bte), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat_i),
        .grant_o(grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [7:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        m_cyc[k] = cyc;
        m_stb[k] = stb;
        m_we[k]  = we;
        m_adr[k*AW +: AW] = adr;
        m_dat[k*DW +: DW] = dat;
        m_cti[k*3 +: 3]   = cti;
    endtask

    task automatic push(input logic [2:0] g, input logic [7:0] a, input logic [31:0] d, input logic [2:0] c);
        exp_t e;
        e.gnt = g;
        e.adr = a;
        e.dat = d;
        e.cti = c;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed empty scoreboard expected a pending transfer", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_grant"}, 64'(grant), 64'(e.gnt));
            chk({tag, "_adr"}, 64'(s_adr), 64'(e.adr));
            chk({tag, "_dat"}, 64'(s_dat_o), 64'(e.dat));
            chk({tag, "_cti"}, 64'(s_cti), 64'(e.cti));
        end
    endtask

    initial begin
        rst = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '1; m_we = '0; m_cyc = '0; m_stb = '0;
        m_cti = '0; m_bte = '0;
        s_ack = 1'b0; s_err = 1'b0; s_dat_i = '0;
        #3;
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_scyc", 64'(s_cyc), 64'(0));
        chk("rst_ack", 64'(m_ack), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        // two masters request together: master 0 wins first
        drive(0, 1, 1, 1, 8'h10, 32'hDEADBEEF, 3'b000);
        drive(1, 1, 1, 0, 8'h30, 32'h11111111, 3'b000);
        push(3'b001, 8'h10, 32'hDEADBEEF, 3'b000);
        #1;
        chk("arb_idle_grant", 64'(grant), 64'(0));
        chk("arb_idle_scyc", 64'(s_cyc), 64'(0));
        tick();
        chk("t1_grant", 64'(grant), 64'(3'b001));
        chk("t1_we", 64'(s_we), 64'(1));
        s_ack = 1'b1;
        #1;
        chk("t1_ack", 64'(m_ack), 64'(3'b001));
        pop_check("t1");
        tick();
        drive(0, 0, 0, 0, 8'h10, 32'hDEADBEEF, 3'b000);
        s_ack = 1'b0;
        #1;
        chk("t1_drop_ack", 64'(m_ack), 64'(0));
        chk("t1_drop_scyc", 64'(s_cyc), 64'(0));
        tick();
        chk("dead_grant", 64'(grant), 64'(0));
        tick();
        chk("t2_grant", 64'(grant), 64'(3'b010));
        // master 1 bursts while master 0 waits
        drive(0, 1, 1, 0, 8'h40, 32'h0, 3'b000);
        for (int b = 0; b < 4; b++) begin
            drive(1, 1, 1, 1, 8'(8'h20 + 4*b), 32'(32'hA0 + b), (b == 3) ? 3'b111 : 3'b010);
            push(3'b010, 8'(8'h20 + 4*b), 32'(32'hA0 + b), (b == 3) ? 3'b111 : 3'b010);
            s_ack = 1'b1;
            #1;
            chk("burst_ack", 64'(m_ack), 64'(3'b010));
            pop_check("burst");
            tick();
        end
        drive(1, 0, 0, 0, 8'h00, 32'h0, 3'b000);
        s_ack = 1'b0;
        #1;
        chk("burst_end_ack", 64'(m_ack), 64'(0));
        chk("burst_end_grant", 64'(grant), 64'(3'b010));
        tick();
        chk("burst_dead", 64'(grant), 64'(0));
        tick();
        chk("m0_after_burst", 64'(grant), 64'(3'b001));
        // all three request continuously: strict rotation
        for (int i = 0; i < 6; i++) begin
            int e;
            e = i % 3;
            for (int k = 0; k < NM; k++) drive(k, 1, 1, 0, 8'(8'h50 + k), 32'(32'h100 + k), 3'b000);
            chk("rr_grant", 64'(grant), 64'(1 << e));
            push(3'(1 << e), 8'(8'h50 + e), 32'(32'h100 + e), 3'b000);
            s_ack = 1'b1;
            #1;
            chk("rr_ack", 64'(m_ack), 64'(1 << e));
            pop_check("rr");
            tick();
            drive(e, 0, 0, 0, 8'(8'h50 + e), 32'(32'h100 + e), 3'b000);
            s_ack = 1'b0;
            tick();
            chk("rr_dead", 64'(grant), 64'(0));
            if (i < 5) drive(e, 1, 1, 0, 8'(8'h50 + e), 32'(32'h100 + e), 3'b000);
            else for (int k = 0; k < NM; k++) drive(k, 0, 0, 0, 8'h00, 32'h0, 3'b000);
            tick();
        end
        chk("rr_done_grant", 64'(grant), 64'(0));
        // slave never answers: watchdog error
        drive(1, 1, 1, 0, 8'h08, 32'h0, 3'b000);
        tick();
        chk("to_grant", 64'(grant), 64'(3'b010));
        for (int w = 1; w < TO; w++) begin
            chk("to_wait_err", 64'(m_err), 64'(0));
            chk("to_wait_scyc", 64'(s_cyc), 64'(1));
            tick();
        end
        chk("to_err", 64'(m_err), 64'(3'b010));
        chk("to_scyc", 64'(s_cyc), 64'(0));
        tick();
        drive(1, 0, 0, 0, 8'h08, 32'h0, 3'b000);
        #1;
        chk("to_idle_grant", 64'(grant), 64'(0));
        chk("to_idle_err", 64'(m_err), 64'(0));
        // reset in the middle of a read
        drive(0, 1, 1, 0, 8'h08, 32'h0, 3'b000);
        s_dat_i = 32'hCAFEF00D;
        tick();
        chk("rd_grant", 64'(grant), 64'(3'b001));
        chk("rd_scyc", 64'(s_cyc), 64'(1));
        chk("rd_adr", 64'(s_adr), 64'(8'h08));
        chk("rd_data", 64'(m_dat_o), 64'(32'hCAFEF00D));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_grant", 64'(grant), 64'(0));
        chk("arst_scyc", 64'(s_cyc), 64'(0));
        s_ack = 1'b1;
        #1;
        chk("arst_late_ack", 64'(m_ack), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ack", 64'(m_ack), 64'(0));
        chk("post_rst_grant", 64'(grant), 64'(0));
        s_ack = 1'b0;
        tick();
        chk("post_rst_regrant", 64'(grant), 64'(3'b001));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/peripheral_wb_mpram_arbiter.md
PERIPHERAL_WB_MPRAM_ARBITER -- requirements
Module: peripheral_wb_mpram_arbiter

Interface
REQ-001 SHALL have parameter NM, default 2, meaning number of Wishbone masters (2..8).
REQ-002 SHALL have parameter AW, default 8, meaning address width shared with the memory port.
REQ-003 SHALL have parameter DW, default 32, meaning data width (byte-select width DW/8).
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning maximum wait cycles for slave ack before error.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: wb_clk_i (rising edge) and wb_rst_i.
REQ-006 wb_clk_i  input  1  system clock.
REQ-007 wb_rst_i  input  1  asynchronous active-high reset.
REQ-008 m_adr_i / m_dat_i / m_sel_i  input  NM*AW / NM*DW / NM*DW/8  packed per-master address, write data, byte selects; master k in slice k.
REQ-009 m_we_i / m_cyc_i / m_stb_i  input  NM each  per-master write enable, cycle, strobe.
REQ-010 m_cti_i / m_bte_i  input  NM*3 / NM*2  per-master burst cycle type and burst type.
REQ-011 m_ack_o / m_err_o  output  NM each  per-master acknowledge and error.
REQ-012 m_dat_o  output  DW  read data, broadcast to all masters.
REQ-013 s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o  output  AW, DW, DW/8, 1, 3, 2, 1, 1  slave-side request to the memory port.
REQ-014 s_ack_i / s_err_i / s_dat_i  input  1 / 1 / DW  slave-side response.
REQ-015 grant_o  output  NM  one-hot current owner; all-zero when idle.

Function
REQ-016 SHALL implement FSM with states IDLE and BUSY, plus registered owner index and round-robin pointer (last owner).
REQ-017 In IDLE, when any m_cyc_i bit is high, SHALL select the first requester at or after (last+1) mod NM, register it as owner, and enter BUSY on the next edge (1-cycle arbitration latency).
REQ-018 In BUSY, SHALL drive all s_* request outputs combinationally from the owner's slices; s_cyc_o = owner m_cyc_i, s_stb_o = owner m_cyc_i & m_stb_i.
REQ-019 In IDLE, s_cyc_o, s_stb_o, s_we_o SHALL be 0; other s_* outputs are don't-care.
REQ-020 SHALL route s_ack_i and s_err_i only to the owner's m_ack_o / m_err_o; non-owners see 0 at all times.
REQ-021 SHALL hold the grant while the owner keeps m_cyc_i high, including across incrementing and wrap bursts (cti 010) and back-to-back classic cycles; no preemption.
REQ-022 When the owner deasserts m_cyc_i, SHALL return to IDLE on that edge, updating last to the owner; rearbitration occurs the following cycle (one dead cycle between owners).
REQ-023 An ack arriving in the same cycle the owner drops m_cyc_i SHALL be discarded and not delivered to any master.
REQ-024 SHALL count cycles with s_stb_o high and neither s_ack_i nor s_err_i; at count equal to TIMEOUT it SHALL assert the owner's m_err_o for exactly one cycle, force s_cyc_o low that cycle, and return to IDLE.
REQ-025 Watchdog counter SHALL clear on every s_ack_i/s_err_i, on entry to IDLE, and whenever s_stb_o is low; width is $clog2(TIMEOUT+1).
REQ-026 Simultaneous request from all masters SHALL yield strict rotation: each master obtains one tenure before any master obtains a second.
REQ-027 A master raising m_cyc_i while another owns the bus SHALL simply wait; its request is not latched and it must hold m_cyc_i.

Reset
REQ-028 While wb_rst_i is high, SHALL force state IDLE, grant_o 0, owner 0, last NM-1 (so master 0 wins first), watchdog 0, s_cyc_o/s_stb_o 0, all m_ack_o/m_err_o 0, asynchronously.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer immediately; any later s_ack_i is ignored until a new grant.

Verification
REQ-030 Reset release, master 0 and 1 raise cyc/stb same cycle -> grant_o=01 one cycle later, master 0 write to addr 0x10 data 0xDEADBEEF completes; then grant_o=10 after one idle cycle.
REQ-031 Master 1 issues 4-beat incrementing burst (cti 010,010,010,111) at 0x20 while master 0 requests -> grant_o stays 10 for all 4 acks; master 0 granted only after master 1 drops cyc.
REQ-032 NM=3, all three hold cyc continuously with single transfers -> grant sequence 0,1,2,0,1,2; m_ack_o never asserted for a non-owner.
REQ-033 TIMEOUT=4, slave never acks -> owner m_err_o pulses once on the 4th wait cycle, s_cyc_o low, state IDLE next cycle.
REQ-034 Assert wb_rst_i during master 0 read at 0x08 with s_ack_i pending -> s_cyc_o and grant_o drop to 0 same cycle without a clock edge; late s_ack_i produces no m_ack_o.
